// File: rtl/branch_target_predictor.sv
// ---------------------------------------------------------------------------
// branch_target_predictor
//
// Direct-mapped branch target buffer with a 2-bit saturating direction
// counter per entry. The IF stage looks up the current fetch PC
// combinationally. EX/MEM trains the table when a branch or jump resolves.
//
// Parameters:
//   XLEN      address width
//   ENTRIES   number of BTB entries (power of 2, >= 2)
//   TAG_BITS  stored tag width
//   CTR_ALLOC counter value written when a new entry is allocated
//
// Ports:
//   clk, reset          clock (rising edge), async active-high reset
//   lookup_pc           fetch PC from IF
//   predict_hit         valid entry with matching tag
//   predict_taken       hit and counter MSB set
//   predict_target      stored target if taken, else lookup_pc+4
//   update_valid        resolved branch/jump this cycle
//   update_pc           PC of the resolved instruction
//   update_taken        actual direction
//   update_target       actual taken target
//   update_mispredict   flush happened for this instruction (stats only)
//   flush_all           invalidate every entry on the next edge
//
// Optional feature (macro BTB_STATS_EN):
//   stat_updates        saturating count of update_valid cycles
//   stat_mispredicts    saturating count of update_valid&&update_mispredict
// ---------------------------------------------------------------------------
module branch_target_predictor #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned ENTRIES   = 16,
   parameter int unsigned TAG_BITS  = 8,
   parameter logic [1:0]  CTR_ALLOC = 2'b10
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] lookup_pc,
   output logic            predict_hit,
   output logic            predict_taken,
   output logic [XLEN-1:0] predict_target,
   input  logic            update_valid,
   input  logic [XLEN-1:0] update_pc,
   input  logic            update_taken,
   input  logic [XLEN-1:0] update_target,
   input  logic            update_mispredict,
`ifdef BTB_STATS_EN
   input  logic            flush_all,
   output logic [31:0]     stat_updates,
   output logic [31:0]     stat_mispredicts
`else
   input  logic            flush_all
`endif
);

   localparam int unsigned IDX = $clog2(ENTRIES);

   logic [TAG_BITS-1:0] r_tag    [ENTRIES];
   logic [XLEN-1:0]     r_target [ENTRIES];
   logic [1:0]          r_ctr    [ENTRIES];
   logic                r_valid  [ENTRIES];

   logic [IDX-1:0]      w_lk_idx;
   logic [TAG_BITS-1:0] w_lk_tag;
   logic [IDX-1:0]      w_up_idx;
   logic [TAG_BITS-1:0] w_up_tag;
   logic                w_up_hit;
   logic                w_unused;

   assign w_lk_idx = lookup_pc[IDX+1:2];
   assign w_lk_tag = lookup_pc[IDX+1+TAG_BITS:IDX+2];
   assign w_up_idx = update_pc[IDX+1:2];
   assign w_up_tag = update_pc[IDX+1+TAG_BITS:IDX+2];

   // Only a slice of each PC addresses the table; the rest is dropped here.
   assign w_unused = ^{lookup_pc, update_pc, update_mispredict};

   // Lookup reads registered state only, so an update in the same cycle
   // becomes visible one cycle later.
   always_comb begin
      predict_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
      predict_taken  = predict_hit && r_ctr[w_lk_idx][1];
      predict_target = predict_taken ? r_target[w_lk_idx] : lookup_pc + XLEN'(4);
   end

   assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= 2'b01;
         end
      end else if (flush_all) begin
         // Flush beats any concurrent update; counters and targets survive.
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            r_valid[i] <= 1'b0;
         end
      end else if (update_valid) begin
         if (w_up_hit) begin
            if (update_taken) begin
               r_ctr[w_up_idx]    <= (r_ctr[w_up_idx] == 2'b11) ? 2'b11 : r_ctr[w_up_idx] + 2'b01;
               r_target[w_up_idx] <= update_target;
            end else begin
               r_ctr[w_up_idx]    <= (r_ctr[w_up_idx] == 2'b00) ? 2'b00 : r_ctr[w_up_idx] - 2'b01;
            end
         end else if (update_taken) begin
            // Allocation overwrites whatever alias currently holds the slot.
            r_valid[w_up_idx]  <= 1'b1;
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= update_target;
            r_ctr[w_up_idx]    <= CTR_ALLOC;
         end
      end
   end

`ifdef BTB_STATS_EN
   logic [31:0] r_stat_updates;
   logic [31:0] r_stat_mispredicts;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stat_updates     <= '0;
         r_stat_mispredicts <= '0;
      end else if (update_valid) begin
         if (r_stat_updates != '1) begin
            r_stat_updates <= r_stat_updates + 32'd1;
         end
         if (update_mispredict && (r_stat_mispredicts != '1)) begin
            r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
         end
      end
   end

   assign stat_updates     = r_stat_updates;
   assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_target_predictor
//
// Table of per-cycle vectors (update inputs + lookup with expected outputs),
// expectations queued on drive and popped on sample; plus hand sequences
// for asynchronous reset between edges and the optional statistics.
// ---------------------------------------------------------------------------
module tb_branch_target_predictor;

   logic        clk;
   logic        reset;
   logic [31:0] lookup_pc;
   logic        predict_hit;
   logic        predict_taken;
   logic [31:0] predict_target;
   logic        update_valid;
   logic [31:0] update_pc;
   logic        update_taken;
   logic [31:0] update_target;
   logic        update_mispredict;
   logic        flush_all;
`ifdef BTB_STATS_EN
   logic [31:0] stat_updates;
   logic [31:0] stat_mispredicts;
`endif

   int n_checks;
   int n_fail;

   branch_target_predictor #(
      .XLEN(32),
      .ENTRIES(16),
      .TAG_BITS(8),
      .CTR_ALLOC(2'b10)
   ) dut (
      .clk(clk),
      .reset(reset),
      .lookup_pc(lookup_pc),
      .predict_hit(predict_hit),
      .predict_taken(predict_taken),
      .predict_target(predict_target),
      .update_valid(update_valid),
      .update_pc(update_pc),
      .update_taken(update_taken),
      .update_target(update_target),
      .update_mispredict(update_mispredict),
`ifdef BTB_STATS_EN
      .flush_all(flush_all),
      .stat_updates(stat_updates),
      .stat_mispredicts(stat_mispredicts)
`else
      .flush_all(flush_all)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utgt;
      logic        fl;
      logic [31:0] lpc;
      logic        ehit;
      logic        etak;
      logic [31:0] etgt;
   } vec_t;

   typedef struct {
      int          row;
      logic        ehit;
      logic        etak;
      logic [31:0] etgt;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   task automatic add(input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic fl, input logic [31:0] lpc,
                      input logic ehit, input logic etak, input logic [31:0] etgt);
      vec_t v;
      v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.fl = fl;
      v.lpc = lpc; v.ehit = ehit; v.etak = etak; v.etgt = etgt;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int row,
                        input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (row %0d): got 0x%08h expected 0x%08h", name, row, act, exp);
      end
   endtask

   task automatic check_lookup(input string name, input int row, input logic ehit,
                               input logic etak, input logic [31:0] etgt);
      check({name, ".hit"}, row, {31'd0, predict_hit}, {31'd0, ehit});
      check({name, ".taken"}, row, {31'd0, predict_taken}, {31'd0, etak});
      check({name, ".target"}, row, predict_target, etgt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      n_checks = 0;
      n_fail   = 0;

      //   uv  upc           ut  utgt          fl  lookup        hit tak target
      add(0, 32'h0,        0, 32'h0,     0, 32'h100,      0, 0, 32'h104);   // 0 cold
      add(0, 32'h0,        0, 32'h0,     0, 32'hFFFFFFFC, 0, 0, 32'h0);     // 1 +4 wraps
      add(1, 32'h100,      1, 32'h80,    0, 32'h100,      0, 0, 32'h104);   // 2 alloc, no bypass
      add(0, 32'h0,        0, 32'h0,     0, 32'h100,      1, 1, 32'h80);    // 3 hit ctr=10
      add(1, 32'h100,      0, 32'h0,     0, 32'h100,      1, 1, 32'h80);    // 4 ->01
      add(1, 32'h100,      0, 32'h0,     0, 32'h100,      1, 0, 32'h104);   // 5 ->00
      add(1, 32'h100,      0, 32'h0,     0, 32'h100,      1, 0, 32'h104);   // 6 stays 00
      add(1, 32'h100,      1, 32'h300,   0, 32'h100,      1, 0, 32'h104);   // 7 ->01
      add(1, 32'h100,      1, 32'h340,   0, 32'h100,      1, 0, 32'h104);   // 8 ->10
      add(0, 32'h0,        0, 32'h0,     0, 32'h100,      1, 1, 32'h340);   // 9 last target
      add(1, 32'h2100,     0, 32'h0,     0, 32'h2100,     0, 0, 32'h2104);  // 10 alias miss, nt
      add(1, 32'h2100,     1, 32'h500,   0, 32'h100,      1, 1, 32'h340);   // 11 alias alloc
      add(0, 32'h0,        0, 32'h0,     0, 32'h100,      0, 0, 32'h104);   // 12 replaced
      add(0, 32'h0,        0, 32'h0,     0, 32'h2100,     1, 1, 32'h500);   // 13
      add(1, 32'h200,      1, 32'h600,   1, 32'h200,      0, 0, 32'h204);   // 14 flush+update
      add(0, 32'h0,        0, 32'h0,     0, 32'h200,      0, 0, 32'h204);   // 15 no alloc
      add(0, 32'h0,        0, 32'h0,     0, 32'h2100,     0, 0, 32'h2104);  // 16 flushed
      add(1, 32'h200,      1, 32'h700,   0, 32'h200,      0, 0, 32'h204);   // 17 alloc 10
      add(0, 32'h0,        0, 32'h0,     0, 32'h200,      1, 1, 32'h700);   // 18
      add(1, 32'h200,      1, 32'h700,   0, 32'h200,      1, 1, 32'h700);   // 19 ->11
      add(1, 32'h200,      1, 32'h700,   0, 32'h200,      1, 1, 32'h700);   // 20 stays 11
      add(1, 32'h200,      0, 32'h0,     0, 32'h200,      1, 1, 32'h700);   // 21 ->10
      add(1, 32'h200,      0, 32'h0,     0, 32'h200,      1, 1, 32'h700);   // 22 ->01
      add(0, 32'h0,        0, 32'h0,     0, 32'h200,      1, 0, 32'h204);   // 23
      add(0, 32'h0,        0, 32'h0,     0, 32'h204,      0, 0, 32'h208);   // 24 other index

      reset = 1'b1;
      lookup_pc = 32'h0; update_valid = 1'b0; update_pc = 32'h0;
      update_taken = 1'b0; update_target = 32'h0; update_mispredict = 1'b0;
      flush_all = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         update_valid  = vecs[i].uv;
         update_pc     = vecs[i].upc;
         update_taken  = vecs[i].ut;
         update_target = vecs[i].utgt;
         flush_all     = vecs[i].fl;
         lookup_pc     = vecs[i].lpc;
         sb.push_back('{row: i, ehit: vecs[i].ehit, etak: vecs[i].etak, etgt: vecs[i].etgt});
         #2;
         e = sb.pop_front();
         check_lookup("vec", e.row, e.ehit, e.etak, e.etgt);
      end

      // Reset pulsed between edges clears the table without a clock edge.
      @(negedge clk);
      update_valid = 1'b0; flush_all = 1'b0;
      lookup_pc = 32'h200;
      #1 check_lookup("pre_async_reset", 100, 1'b1, 1'b0, 32'h204);
      reset = 1'b1;
      #1 check_lookup("async_reset", 101, 1'b0, 1'b0, 32'h204);
      reset = 1'b0;
      @(negedge clk);
      check_lookup("after_async_reset", 102, 1'b0, 1'b0, 32'h204);

`ifdef BTB_STATS_EN
      check("stat_updates.reset", 200, stat_updates, 32'd0);
      check("stat_mispredicts.reset", 200, stat_mispredicts, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         update_valid      = 1'b1;
         update_pc         = 32'h400 + 32'(i * 4);
         update_taken      = 1'b1;
         update_target     = 32'h900;
         update_mispredict = (i == 1 || i == 3);
      end
      @(negedge clk);
      update_valid = 1'b0; update_mispredict = 1'b0;
      check("stat_updates.count", 201, stat_updates, 32'd5);
      check("stat_mispredicts.count", 201, stat_mispredicts, 32'd2);
      // Mispredict without update_valid is not counted.
      update_mispredict = 1'b1;
      flush_all = 1'b1;
      @(negedge clk);
      flush_all = 1'b0; update_mispredict = 1'b0;
      check("stat_updates.flush", 202, stat_updates, 32'd5);
      check("stat_mispredicts.flush", 202, stat_mispredicts, 32'd2);
      reset = 1'b1;
      #1;
      check("stat_updates.reset2", 203, stat_updates, 32'd0);
      check("stat_mispredicts.reset2", 203, stat_mispredicts, 32'd0);
      reset = 1'b0;
`endif

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
